// File: rtl/mfp_ahb_dma_master_if.sv
// AHB-lite bus bundle between the DMA master and the fabric.
// The master modport drives the address/control/write-data side; the slave modport answers.
interface mfp_ahb_dma_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_dma_master.sv
// Single-channel AHB-lite DMA master: copies word_count 32-bit words from src to dst,
// one NONSEQ read then one NONSEQ write per word, with wait-state and ERROR handling.
module mfp_ahb_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     words_left,
  mfp_ahb_dma_master_if.master ahb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_FINISH
  } state_t;

  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      buf_q, buf_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    buf_d        = buf_q;
    words_left_d = words_left_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    hwrite_d     = hwrite_q;

    case (state_q)
      S_IDLE: begin
        htrans_d = TR_IDLE;
        if (start) begin
          error_d = 1'b0;
          if (word_count != '0) begin
            src_d        = src_addr & WORD_MASK;
            dst_d        = dst_addr & WORD_MASK;
            words_left_d = word_count;
            busy_d       = 1'b1;
            haddr_d      = src_addr & WORD_MASK;
            htrans_d     = TR_NONSEQ;
            hwrite_d     = 1'b0;
            state_d      = S_RD_ADDR;
          end else begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end

      S_RD_ADDR: begin
        if (ahb.HREADY) begin
          htrans_d = TR_IDLE;
          state_d  = S_RD_DATA;
        end
      end

      // ERROR is acted on in its first cycle so the second cycle already sees IDLE.
      S_RD_DATA: begin
        if (ahb.HRESP) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ahb.HREADY) begin
          buf_d    = ahb.HRDATA;
          haddr_d  = dst_q;
          htrans_d = TR_NONSEQ;
          hwrite_d = 1'b1;
          state_d  = S_WR_ADDR;
        end
      end

      S_WR_ADDR: begin
        if (ahb.HREADY) begin
          htrans_d = TR_IDLE;
          state_d  = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (ahb.HRESP) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ahb.HREADY) begin
          src_d        = src_q + 32'd4;
          dst_d        = dst_q + 32'd4;
          words_left_d = words_left_q - CNT_W'(1);
          if (words_left_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            haddr_d  = src_q + 32'd4;
            htrans_d = TR_NONSEQ;
            hwrite_d = 1'b0;
            state_d  = S_RD_ADDR;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        htrans_d = TR_IDLE;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      buf_q        <= '0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      haddr_q      <= '0;
      htrans_q     <= TR_IDLE;
      hwrite_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      buf_q        <= buf_d;
      words_left_q <= words_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      hwrite_q     <= hwrite_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_left     = words_left_q;
  assign ahb.HADDR      = haddr_q;
  assign ahb.HTRANS     = htrans_q;
  assign ahb.HWRITE     = hwrite_q;
  assign ahb.HWDATA     = buf_q;
  assign ahb.HSIZE      = 3'b010;
  assign ahb.HBURST     = 3'b000;
  assign ahb.HPROT      = 4'b0011;
  assign ahb.HMASTLOCK  = 1'b0;

endmodule

// File: doc/mfp_ahb_dma_master.md
Name: mfp_ahb_dma_master

Overview:
Single-channel AHB-lite bus master (initiator) that copies a block of 32-bit words from a source address to a destination address over the existing AHB-lite fabric. It drives the master side of the bus that the decoder and slaves respond to. It is configured and started from a simple local control interface. Each word is moved as a single NONSEQ read followed by a single NONSEQ write, with full HREADY wait-state and HRESP error handling.

Parameters:
CNT_W, 16, width of the word-count input and the words_left output.

Ports:
HCLK  input  1  bus clock; the only clock.
HRESETn  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0).
dst_addr  input  32  destination byte address; bits [1:0] ignored.
word_count  input  CNT_W  number of words to copy.
busy  output  1  high from the cycle after an accepted start until completion or abort.
done  output  1  one-cycle pulse on successful completion.
error  output  1  sticky; set on HRESP error, cleared by the next accepted start.
words_left  output  CNT_W  remaining words.
HADDR  output  32  address-phase address.
HTRANS  output  2  2'b00 IDLE or 2'b10 NONSEQ only.
HWRITE  output  1  address-phase direction.
HSIZE  output  3  constant 3'b010 (word).
HBURST  output  3  constant 3'b000 (SINGLE).
HPROT  output  4  constant 4'b0011.
HMASTLOCK  output  1  constant 0.
HWDATA  output  32  write data, valid in the write data phase.
HRDATA  input  32  read data.
HREADY  input  1  transfer-complete / wait-state indication.
HRESP  input  1  1 = ERROR.

Behaviour:
- Reset: a synchronous reset (HRESETn=0 at a rising edge) is already decided. After reset: state IDLE; busy=0, done=0, error=0, words_left=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
- Reset mid-transfer: reset in any state returns to IDLE at that edge. No further bus cycles are issued and no done pulse is produced.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
- IDLE: HTRANS=IDLE.
  - start=1 with word_count!=0: latch src_addr&~3, dst_addr&~3 and word_count; set busy; clear error; go to RD_ADDR.
  - start=1 with word_count==0: go to FINISH with no bus activity.
- RD_ADDR: HADDR=src pointer, HTRANS=NONSEQ, HWRITE=0. Hold all signals while HREADY=0. On HREADY=1 go to RD_DATA.
- RD_DATA: HTRANS=IDLE.
  - HREADY=1 and HRESP=0: capture HRDATA into the internal word buffer; go to WR_ADDR.
- WR_ADDR: HADDR=dst pointer, HTRANS=NONSEQ, HWRITE=1. Hold while HREADY=0. On HREADY=1 go to WR_DATA.
- WR_DATA: HTRANS=IDLE, HWDATA=buffer (held stable for the whole data phase). On HREADY=1 and HRESP=0:
  - src += 4, dst += 4, words_left -= 1.
  - If the new words_left is 0, go to FINISH; otherwise go to RD_ADDR.
- FINISH: done=1 and busy=0 for exactly one cycle; return to IDLE. start is ignored in FINISH.
- Error: HRESP=1 in RD_DATA or WR_DATA (first error cycle, regardless of HREADY):
  - Set error and go to IDLE; busy=0; no done pulse.
  - words_left keeps the count of uncompleted words, including the failed one.
  - The second error cycle sees HTRANS=IDLE, as the protocol requires.
- start while busy is ignored and has no effect on the latched parameters.
- Pointer arithmetic is modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.
- Latency with zero wait states: 4 cycles per word (one each in RD_ADDR, RD_DATA, WR_ADDR, WR_DATA). Each HREADY=0 cycle adds one cycle to the phase it occurs in.
- Only one transfer is outstanding at a time. Address and data phases of different transfers never overlap.

Test Plan:
- Zero-wait copy: src=0xBFC00000, dst=0x80000100, count=3; RAM holds 0x11111111/0x22222222/0x33333333 -> writes land at 0x80000100/104/108 with the same data; done pulses exactly 12 cycles after start is accepted; busy falls with done.
- Wait states: count=1, slave inserts 2 HREADY=0 cycles in the read data phase and 1 in the write address phase -> HADDR/HTRANS/HWRITE/HWDATA held stable; done arrives 3 cycles later than the zero-wait case.
- Zero count: start with count=0 -> HTRANS stays 2'b00; done pulses one cycle after start; error stays 0.
- Error abort: count=4, HRESP=1 on the 2nd word's read data phase -> error=1, busy=0, no done pulse, words_left=3, no NONSEQ for the 2nd word's write; the next start clears error.
- Reset mid-op: assert HRESETn=0 for one edge during WR_ADDR -> HTRANS=2'b00 and busy=0 on the following cycle; no done pulse.
- Wrap and ignored start: src=0xFFFFFFFC, count=2, with start pulsed again during RD_DATA -> 2nd read address is 0x00000000; the second start has no effect.
